data_mem_wait: RTL

- Parametrised byte-addressable data memory for the CPU load/store path.
- Uses a valid/ready request handshake and a configurable wait-state count.
- Supports byte and halfword accesses, with sign- or zero-extension on byte loads.
- Misaligned and out-of-range accesses report an error; they are never silently truncated. Sits between the execute/memory stage and local data storage.

---
 rtl/data_mem_pkg.sv | 19 +
 rtl/data_mem_wait_array.sv | 37 +++
 rtl/data_mem_wait.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types and constants for the data_mem_wait block.
//   state_t  - controller states (IDLE, WAIT, RESP)
//   SZ_BYTE  - req_size encoding for byte accesses
//   SZ_HALF  - req_size encoding for halfword accesses
//   CNT_W    - width of the wait-state down-counter (WAIT_CYCLES 0..15)
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic SZ_BYTE = 1'b0;
    localparam logic SZ_HALF = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/data_mem_wait_array.sv
// dm_byte_array: DEPTH_BYTES x 8 storage, no reset.
// Two byte write ports (A and B, each behind its own enable) and two
// combinational byte read ports at the same indices. Contents start at zero
// at time 0 and are never cleared afterwards.
//   clk      in   clock
//   we_a     in   write enable, port A
//   addr_a   in   byte index, port A
//   wdata_a  in   write byte, port A
//   rdata_a  out  read byte at addr_a
//   we_b/addr_b/wdata_b/rdata_b  same for port B
module dm_byte_array #(
    parameter int DEPTH_BYTES = 64,
    parameter int IDX_W       = 6
) (
    input  logic             clk,
    input  logic             we_a,
    input  logic [IDX_W-1:0] addr_a,
    input  logic [7:0]       wdata_a,
    output logic [7:0]       rdata_a,
    input  logic             we_b,
    input  logic [IDX_W-1:0] addr_b,
    input  logic [7:0]       wdata_b,
    output logic [7:0]       rdata_b
);

    logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};

    // The caller never drives A and B to the same index while both enables are set.
    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= wdata_a;
        if (we_b) mem[addr_b] <= wdata_b;
    end

    assign rdata_a = mem[addr_a];
    assign rdata_b = mem[addr_b];

endmodule

// File: rtl/data_mem_wait.sv
// data_mem_wait: byte-addressable data memory with a valid/ready request
// handshake and WAIT_CYCLES wait states between acceptance and commit.
// Big-endian halfwords; byte loads sign- or zero-extend. Misaligned or
// out-of-range accesses commit nothing and respond with rsp_err=1.
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted (IDLE only)
//   req_we     in   1 = write, 0 = read
//   req_size   in   0 = byte, 1 = halfword
//   req_signed in   byte reads: 1 = sign-extend
//   req_addr   in   byte address
//   req_wdata  in   write data (bytes use [7:0])
//   rsp_valid  out  one-cycle response pulse
//   rsp_rdata  out  read data, 0 for writes and errors
//   rsp_err    out  access was misaligned or out of range
//
// state | meaning
// IDLE  | ready; accept request, load wait counter
// WAIT  | counting down wait states, commit when counter is 1
// RESP  | rsp_valid pulse, back to IDLE
module data_mem_wait
    import data_mem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_BYTES = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int AEW   = ADDR_W + 1;
    localparam logic [ADDR_W:0]  DEPTH_LIM = AEW'(DEPTH_BYTES);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              cap_we, cap_size, cap_signed;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              accept, commit;
    logic              acc_we, acc_size, acc_signed, acc_err;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [ADDR_W:0]   acc_last;
    logic [IDX_W-1:0]  idx_a, idx_b;
    logic [7:0]        rbyte_a, rbyte_b;
    logic              we_a, we_b;
    logic [DATA_W-1:0] rd_val;

    assign accept = (state_q == IDLE) && req_valid;
    assign commit = (accept && (WAIT_CYCLES == 0)) ||
                    ((state_q == WAIT) && (cnt_q == CNT_W'(1)));

    // With zero wait states the commit happens on the acceptance edge, before
    // the capture registers hold the request, so use the live inputs then.
    assign acc_we     = (state_q == IDLE) ? req_we     : cap_we;
    assign acc_size   = (state_q == IDLE) ? req_size   : cap_size;
    assign acc_signed = (state_q == IDLE) ? req_signed : cap_signed;
    assign acc_addr   = (state_q == IDLE) ? req_addr   : cap_addr;
    assign acc_wdata  = (state_q == IDLE) ? req_wdata  : cap_wdata;

    // Last byte touched, one bit wider so A+1 cannot wrap past the top address.
    assign acc_last = {1'b0, acc_addr} + {{ADDR_W{1'b0}}, (acc_size == SZ_HALF)};
    assign acc_err  = ((acc_size == SZ_HALF) && acc_addr[0]) || (acc_last >= DEPTH_LIM);

    // Indices are forced to 0 on error so the array is never addressed out of bounds.
    assign idx_a = acc_err ? '0 : acc_addr[IDX_W-1:0];
    assign idx_b = (acc_err || (acc_size == SZ_BYTE)) ? '0 : idx_a + IDX_W'(1);

    assign we_a = commit && acc_we && !acc_err;
    assign we_b = we_a && (acc_size == SZ_HALF);

    assign rd_val = (acc_size == SZ_HALF) ? {rbyte_a, rbyte_b}
                                          : {{8{acc_signed & rbyte_a[7]}}, rbyte_a};

    dm_byte_array #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_a    (we_a),
        .addr_a  (idx_a),
        .wdata_a ((acc_size == SZ_HALF) ? acc_wdata[DATA_W-1:8] : acc_wdata[7:0]),
        .rdata_a (rbyte_a),
        .we_b    (we_b),
        .addr_b  (idx_b),
        .wdata_b (acc_wdata[7:0]),
        .rdata_b (rbyte_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cap_we     <= 1'b0;
            cap_size   <= 1'b0;
            cap_signed <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cap_we     <= req_we;
                cap_size   <= req_size;
                cap_signed <= req_signed;
                cap_addr   <= req_addr;
                cap_wdata  <= req_wdata;
                cnt_q      <= WAIT_INIT;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (commit) begin
                rdata_q <= (acc_err || acc_we) ? '0 : rd_val;
                err_q   <= acc_err;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
